// File: rtl/serial_io_buffer.sv
// Processor <-> host byte buffer: a TX FIFO (processor to host) and an RX FIFO
// (host to processor), both first-word-fall-through, with sticky error flags.

module serial_io_buffer_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data,
   input  logic       wr_req,
   input  logic       rd_req,
   output logic [7:0] rd_data,
   output logic       not_full,
   output logic       not_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   // Handshakes depend only on registered count, never on the partner's strobe.
   assign not_full  = (count_q != CW'(DEPTH));
   assign not_empty = (count_q != '0);
   assign push      = wr_req & not_full;
   assign pop       = rd_req & not_empty;
   assign rd_data   = mem_q[rptr_q];

   always_comb begin
      // NOTE: defaults first so every path assigns each signal and no latch is inferred.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage has no reset; emptiness is tracked by the count alone.
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= wr_data;
   end
endmodule

module serial_io_buffer #(
   parameter int DEPTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] proc_wdata,
   input  logic       proc_wren,
   input  logic       proc_rden,
   output logic [7:0] proc_rdata,
   output logic       proc_rvalid,
   output logic       proc_wready,
   input  logic [7:0] host_rx_data,
   input  logic       host_rx_valid,
   output logic       host_rx_ready,
   output logic [7:0] host_tx_data,
   output logic       host_tx_valid,
   input  logic       host_tx_ready,
   output logic       tx_overflow,
   output logic       rx_underflow
);
   logic tx_overflow_q, tx_overflow_d;
   logic rx_underflow_q, rx_underflow_d;

   serial_io_buffer_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_data   (proc_wdata),
      .wr_req    (proc_wren),
      .rd_req    (host_tx_ready),
      .rd_data   (host_tx_data),
      .not_full  (proc_wready),
      .not_empty (host_tx_valid)
   );

   serial_io_buffer_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_data   (host_rx_data),
      .wr_req    (host_rx_valid),
      .rd_req    (proc_rden),
      .rd_data   (proc_rdata),
      .not_full  (host_rx_ready),
      .not_empty (proc_rvalid)
   );

   // A write into a full TX flags overflow even if the host pops on the same edge.
   always_comb begin
      tx_overflow_d  = tx_overflow_q  | (proc_wren & ~proc_wready);
      rx_underflow_d = rx_underflow_q | (proc_rden & ~proc_rvalid);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_overflow_q  <= 1'b0;
         rx_underflow_q <= 1'b0;
      end else begin
         tx_overflow_q  <= tx_overflow_d;
         rx_underflow_q <= rx_underflow_d;
      end
   end

   assign tx_overflow  = tx_overflow_q;
   assign rx_underflow = rx_underflow_q;
endmodule

// File: tb/tb_serial_io_buffer.sv
// Self-checking bench for serial_io_buffer: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.

module tb_serial_io_buffer;
   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] proc_wdata = '0;
   logic       proc_wren = 1'b0;
   logic       proc_rden = 1'b0;
   logic [7:0] proc_rdata;
   logic       proc_rvalid;
   logic       proc_wready;
   logic [7:0] host_rx_data = '0;
   logic       host_rx_valid = 1'b0;
   logic       host_rx_ready;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready = 1'b0;
   logic       tx_overflow;
   logic       rx_underflow;

   serial_io_buffer #(.DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .proc_wdata    (proc_wdata),
      .proc_wren     (proc_wren),
      .proc_rden     (proc_rden),
      .proc_rdata    (proc_rdata),
      .proc_rvalid   (proc_rvalid),
      .proc_wready   (proc_wready),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .tx_overflow   (tx_overflow),
      .rx_underflow  (rx_underflow)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_total++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   // Reference model: byte queues and sticky flags, updated from the strobes.
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         txq.delete();
         rxq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         automatic bit tx_full  = (txq.size() == DEPTH);
         automatic bit tx_empty = (txq.size() == 0);
         automatic bit rx_full  = (rxq.size() == DEPTH);
         automatic bit rx_empty = (rxq.size() == 0);
         if (proc_wren && tx_full)  m_ovf = 1'b1;
         if (proc_rden && rx_empty) m_unf = 1'b1;
         if (host_tx_ready && !tx_empty) void'(txq.pop_front());
         if (proc_wren && !tx_full) txq.push_back(proc_wdata);
         if (proc_rden && !rx_empty) void'(rxq.pop_front());
         if (host_rx_valid && !rx_full) rxq.push_back(host_rx_data);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (!reset) begin
         check("model_proc_wready",  32'(proc_wready),   32'(txq.size() != DEPTH));
         check("model_host_tx_valid", 32'(host_tx_valid), 32'(txq.size() != 0));
         check("model_host_rx_ready", 32'(host_rx_ready), 32'(rxq.size() != DEPTH));
         check("model_proc_rvalid",  32'(proc_rvalid),   32'(rxq.size() != 0));
         check("model_tx_overflow",  32'(tx_overflow),   32'(m_ovf));
         check("model_rx_underflow", 32'(rx_underflow),  32'(m_unf));
         if (txq.size() != 0) check("model_host_tx_data", 32'(host_tx_data), 32'(txq[0]));
         if (rxq.size() != 0) check("model_proc_rdata",   32'(proc_rdata),   32'(rxq[0]));
      end
   end

   // Advance one clock: returns just after the following falling edge.
   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic idle();
      proc_wren = 1'b0;
      proc_rden = 1'b0;
      host_rx_valid = 1'b0;
      host_tx_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq [16];

      // Reset state
      #2;
      check("rst_proc_rvalid",   32'(proc_rvalid),   32'd0);
      check("rst_host_tx_valid", 32'(host_tx_valid), 32'd0);
      check("rst_proc_wready",   32'(proc_wready),   32'd1);
      check("rst_host_rx_ready", 32'(host_rx_ready), 32'd1);
      check("rst_flags", 32'({tx_overflow, rx_underflow}), 32'd0);
      step();
      reset = 1'b0;
      step();

      // TX: three writes held, then drained in order
      for (int i = 0; i < 3; i++) begin
         proc_wren = 1'b1;
         proc_wdata = 8'h41 + 8'(i);
         step();
      end
      idle();
      check("tx_hold_valid", 32'(host_tx_valid), 32'd1);
      check("tx_hold_data",  32'(host_tx_data),  32'h41);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("tx_drain_data", 32'(host_tx_data), 32'h41 + 32'(i));
         step();
      end
      idle();
      check("tx_drain_empty", 32'(host_tx_valid), 32'd0);

      // RX: fill to DEPTH, ninth byte held off, nine reads
      for (int i = 0; i < 8; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data = 8'(i);
         step();
      end
      check("rx_full_ready", 32'(host_rx_ready), 32'd0);
      host_rx_data = 8'h08;
      step();
      idle();
      proc_rden = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("rx_read_valid", 32'(proc_rvalid), 32'd1);
         check("rx_read_data",  32'(proc_rdata),  32'(i));
         step();
      end
      check("rx_empty_valid", 32'(proc_rvalid), 32'd0);
      check("rx_no_underflow_yet", 32'(rx_underflow), 32'd0);
      step();
      idle();
      check("rx_underflow_set", 32'(rx_underflow), 32'd1);

      // TX full, write dropped despite simultaneous pop
      for (int i = 0; i < 8; i++) begin
         proc_wren = 1'b1;
         proc_wdata = 8'hA0 + 8'(i);
         step();
      end
      check("tx_full_wready", 32'(proc_wready), 32'd0);
      proc_wdata = 8'hFF;
      host_tx_ready = 1'b1;
      step();
      proc_wren = 1'b0;
      check("tx_overflow_set", 32'(tx_overflow), 32'd1);
      check("tx_count7_wready", 32'(proc_wready), 32'd1);
      for (int i = 1; i < 8; i++) begin
         check("tx_after_drop_data", 32'(host_tx_data), 32'hA0 + 32'(i));
         step();
      end
      idle();
      check("tx_after_drop_empty", 32'(host_tx_valid), 32'd0);
      check("tx_overflow_sticky", 32'(tx_overflow), 32'd1);

      // RX at count 4, simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data = 8'h10 + 8'(i);
         step();
      end
      host_rx_data = 8'h55;
      proc_rden = 1'b1;
      check("rx_sim_head", 32'(proc_rdata), 32'h10);
      step();
      host_rx_valid = 1'b0;
      check("rx_sim_head_after", 32'(proc_rdata), 32'h11);
      begin
         logic [7:0] exp_rx [4];
         exp_rx = '{8'h11, 8'h12, 8'h13, 8'h55};
         for (int i = 0; i < 4; i++) begin
            check("rx_sim_drain", 32'(proc_rdata), 32'(exp_rx[i]));
            step();
         end
      end
      idle();
      check("rx_sim_empty", 32'(proc_rvalid), 32'd0);

      // TX streaming: 16 bytes with continuous push and pop, wrapping twice
      for (int i = 0; i < 16; i++) seq[i] = 8'(i * 7 + 3);
      proc_wren = 1'b1;
      proc_wdata = seq[0];
      step();
      host_tx_ready = 1'b1;
      for (int k = 1; k < 16; k++) begin
         proc_wdata = seq[k];
         check("tx_stream_data", 32'(host_tx_data), 32'(seq[k-1]));
         step();
      end
      proc_wren = 1'b0;
      check("tx_stream_last", 32'(host_tx_data), 32'(seq[15]));
      step();
      idle();
      check("tx_stream_empty", 32'(host_tx_valid), 32'd0);

      // Reset pulsed between edges with 5 bytes in RX
      for (int i = 0; i < 5; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data = 8'h60 + 8'(i);
         step();
      end
      idle();
      check("pre_reset_rvalid", 32'(proc_rvalid), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("midrst_proc_rvalid", 32'(proc_rvalid), 32'd0);
      check("midrst_flags", 32'({tx_overflow, rx_underflow}), 32'd0);
      check("midrst_proc_wready", 32'(proc_wready), 32'd1);
      check("midrst_host_rx_ready", 32'(host_rx_ready), 32'd1);
      #1 reset = 1'b0;
      step();
      host_rx_valid = 1'b1;
      host_rx_data = 8'h99;
      step();
      host_rx_valid = 1'b0;
      check("post_rst_valid", 32'(proc_rvalid), 32'd1);
      check("post_rst_data",  32'(proc_rdata),  32'h99);
      proc_rden = 1'b1;
      step();
      idle();
      check("post_rst_empty", 32'(proc_rvalid), 32'd0);
      check("post_rst_flags", 32'({tx_overflow, rx_underflow}), 32'd0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
